dual_dds_scheduler: RTL and testbench
=====================================

# dual_dds_scheduler

Time-shares one registered waveform ROM (1024 x 4, one-cycle read latency) between two DDS channels A and B. Each channel has its own phase accumulator and frequency tuning word (FTW). A fixed three-cycle frame FSM issues the ROM reads and latches the returned samples into two DAC output registers. A one-entry valid/ready configuration port loads FTWs and phase clears, which take effect only at frame boundaries. The block sits between the control logic (switches/keys or a host) and the shared waveform ROM that drives the VGA-pin DAC outputs.

## Interface
- ADDR_W, 10, ROM address width
- DATA_W, 4, ROM/DAC sample width
- ACC_W, 16, phase accumulator and FTW width (ACC_W >= ADDR_W); ROM address = acc[ACC_W-1 -: ADDR_W]

- sys_clk  in  1  system clock; all logic on its rising edge
- sys_rst  in  1  synchronous, active-high reset
- run  in  1  enables frame sequencing
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept; a transfer occurs when cfg_valid && cfg_ready
- cfg_ch  in  1  target channel: 0 = A, 1 = B
- cfg_ftw  in  ACC_W  new tuning word
- cfg_clr  in  1  clear the target accumulator when the config is applied
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM read address; 0 whenever rom_en = 0
- rom_data  in  DATA_W  ROM output, valid one cycle after the rom_en/rom_addr cycle
- dac_a  out  DATA_W  channel A sample (registered)
- dac_b  out  DATA_W  channel B sample (registered)
- sample_tick  out  1  one-cycle pulse, high in the cycle both DAC outputs hold the samples of the frame just completed

## Operation
FSM states: IDLE, ISSUE_A, ISSUE_B, CAP_B.
- **IDLE**
  - rom_en = 0.
  - If run = 1, go to ISSUE_A; otherwise stay.
- **ISSUE_A**
  - rom_en = 1, rom_addr = top bits of acc_a.
  - Go to ISSUE_B.
- **ISSUE_B**
  - rom_en = 1, rom_addr = top bits of acc_b.
  - dac_a <= rom_data (channel A data).
  - Go to CAP_B.
- **CAP_B** (frame boundary)
  - rom_en = 0.
  - dac_b <= rom_data.
  - acc_x <= acc_x + ftw_x for both channels, modulo 2^ACC_W.
  - The pending config, if any, is applied.
  - sample_tick register is set, so the pulse appears in the next cycle.
  - Go to ISSUE_A if run = 1, else IDLE.
- **run sampling**
  - run is sampled only in IDLE and CAP_B.
  - Deasserting run mid-frame completes the frame.
  - In IDLE the DAC outputs and accumulators hold.
- **Config buffer** (one entry: pend_valid, pend_ch, pend_ftw, pend_clr)
  - cfg_ready = ~pend_valid & ~sys_rst.
  - An accepted transfer sets pend_valid.
  - Pending config is applied in CAP_B, or in any IDLE cycle.
  - Applying sets ftw_x <= pend_ftw and clears pend_valid.
  - If pend_clr = 1, acc_x <= 0, overriding that cycle's increment. Otherwise the increment uses the old FTW.
  - The new FTW governs increments from the next frame on.
  - An accept and an apply never occur in the same cycle, because cfg_ready is low while pending.
- **Reset**
  - State = IDLE; acc_a, acc_b, ftw_a, ftw_b = 0; dac_a = dac_b = 0.
  - sample_tick = 0, rom_en = 0, rom_addr = 0, pend_valid = 0.
  - Reset overrides every other event, including mid-frame and pending config.

## Timing
- Frame length is exactly 3 cycles when run is held high. sample_tick fires once every 3 cycles.
- Latencies from the ISSUE_A cycle (cycle 0):
  - dac_a updates at the cycle 1 edge and is visible in cycle 2.
  - dac_b updates at the cycle 2 edge and is visible in cycle 3, coincident with sample_tick.
- run rising while in IDLE: the first ISSUE_A occurs in the next cycle.
- Config accepted in cycle t:
  - Running: applied at the next CAP_B edge. cfg_ready returns high the cycle after that CAP_B.
  - In IDLE: applied at edge t+1; cfg_ready is high again in cycle t+2.
- The accumulator wraps silently modulo 2^ACC_W. There is no saturation or overflow flag.
- With default parameters, the address advances by 1 ROM entry per frame for FTW = 0x0040.

## Test plan
Bench ROM model: rom_data = rom_addr[3:0], one-cycle latency.
1. **Reset:** assert sys_rst 2 cycles.
   - During reset: dac_a = dac_b = 0, rom_en = 0, rom_addr = 0, sample_tick = 0, cfg_ready = 0.
   - First cycle after: cfg_ready = 1.
2. **Basic run:** configure A FTW = 0x0040, B FTW = 0x0080 in IDLE, then run = 1.
   - At successive sample_ticks: (dac_a, dac_b) = (0,0), (1,2), (2,4), (3,6).
   - Exactly 3 cycles between ticks.
3. **Wrap:** A FTW = 0xFFC0 (decrementing), cfg_clr = 1.
   - dac_a at successive ticks = 0, F, E, D (addresses 0, 0x3FF, 0x3FE, 0x3FD).
4. **Back-pressure:** while running, hold cfg_valid for two configs (A = 0x0100, then B = 0x0040).
   - The first is accepted immediately and cfg_ready drops.
   - The second is accepted in the cycle after the next CAP_B.
   - A steps by 4 from the frame after its CAP_B apply. B changes step from the frame after its own CAP_B apply; it is not applied in the same frame as A.
5. **Run drop / clear:**
   - Drop run during ISSUE_B: the frame completes, sample_tick fires once, the FSM goes to IDLE, and the DACs hold.
   - Then send B cfg_clr = 1 in IDLE and re-run: first B sample = 0.
6. **Mid-frame reset:** assert sys_rst in the ISSUE_B cycle.
   - Next cycle: all outputs are 0 and the FSM is in IDLE.
   - Pending config is discarded; the FTWs read back via samples as 0 (constant dac_a = dac_b = 0).

Source files
------------

// File: rtl/dual_dds_scheduler.sv
// dual_dds_scheduler
//   Two DDS channels (A, B) time-share one registered waveform ROM with a
//   one-cycle read latency. A fixed three-cycle frame issues the A read, then
//   the B read, then captures B and advances both phase accumulators. A
//   one-entry config buffer holds FTW/clear updates until a frame boundary
//   (CAP_B) or any IDLE cycle.
//
// Ports
//   sys_clk, sys_rst       clock, synchronous active-high reset
//   run                    enables frame sequencing (sampled in IDLE/CAP_B)
//   cfg_valid/cfg_ready    config handshake; cfg_ch selects A(0)/B(1)
//   cfg_ftw, cfg_clr       new tuning word, clear target accumulator
//   rom_en, rom_addr       ROM read strobe and address (address 0 when idle)
//   rom_data               ROM sample, valid the cycle after the read
//   dac_a, dac_b           registered channel samples
//   sample_tick            pulse in the cycle both DACs hold the new frame
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | not sequencing; DACs and accumulators hold, config applies here
// ISSUE_A | read ROM at channel A phase
// ISSUE_B | read ROM at channel B phase, capture A sample
// CAP_B   | capture B sample, advance accumulators, apply pending config
module dual_dds_scheduler #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4,
  parameter int ACC_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              run,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_ch,
  input  logic [ACC_W-1:0]  cfg_ftw,
  input  logic              cfg_clr,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] dac_a,
  output logic [DATA_W-1:0] dac_b,
  output logic              sample_tick
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_A = 2'd1,
    ISSUE_B = 2'd2,
    CAP_B   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0] acc_a, acc_b;
  logic [ACC_W-1:0] ftw_a, ftw_b;

  logic             pend_valid;
  logic             pend_ch;
  logic [ACC_W-1:0] pend_ftw;
  logic             pend_clr;

  logic cfg_accept;
  logic cfg_apply;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; run is only looked at on frame boundaries
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = ISSUE_A;
      ISSUE_A: state_nxt = ISSUE_B;
      ISSUE_B: state_nxt = CAP_B;
      CAP_B:   state_nxt = run ? ISSUE_A : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ROM request outputs
  always_comb begin
    rom_en   = 1'b0;
    rom_addr = '0;
    case (state)
      ISSUE_A: begin
        rom_en   = 1'b1;
        rom_addr = acc_a[ACC_W-1 -: ADDR_W];
      end
      ISSUE_B: begin
        rom_en   = 1'b1;
        rom_addr = acc_b[ACC_W-1 -: ADDR_W];
      end
      default: ;
    endcase
  end

  // Ready is held low during reset so nothing is accepted into a buffer
  // that is about to be cleared.
  assign cfg_ready  = ~pend_valid & ~sys_rst;
  assign cfg_accept = cfg_valid & cfg_ready;
  assign cfg_apply  = pend_valid & ((state == IDLE) | (state == CAP_B));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pend_valid <= 1'b0;
      pend_ch    <= 1'b0;
      pend_ftw   <= '0;
      pend_clr   <= 1'b0;
    end else if (cfg_accept) begin
      pend_valid <= 1'b1;
      pend_ch    <= cfg_ch;
      pend_ftw   <= cfg_ftw;
      pend_clr   <= cfg_clr;
    end else if (cfg_apply) begin
      pend_valid <= 1'b0;
    end
  end

  // Accumulators advance with the FTW in force during the frame; a clear
  // from the applied config wins over that frame's increment.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc_a <= '0;
      acc_b <= '0;
      ftw_a <= '0;
      ftw_b <= '0;
    end else begin
      if (state == CAP_B) begin
        acc_a <= acc_a + ftw_a;
        acc_b <= acc_b + ftw_b;
      end
      if (cfg_apply) begin
        if (!pend_ch) begin
          ftw_a <= pend_ftw;
          if (pend_clr) acc_a <= '0;
        end else begin
          ftw_b <= pend_ftw;
          if (pend_clr) acc_b <= '0;
        end
      end
    end
  end

  // Sample capture: ROM data in ISSUE_B belongs to the A read, in CAP_B to B
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dac_a       <= '0;
      dac_b       <= '0;
      sample_tick <= 1'b0;
    end else begin
      if (state == ISSUE_B) dac_a <= rom_data;
      if (state == CAP_B)   dac_b <= rom_data;
      sample_tick <= (state == CAP_B);
    end
  end

endmodule

// File: tb/tb_dual_dds_scheduler.sv
module tb_dual_dds_scheduler;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        run = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        cfg_ch = 1'b0;
  logic [15:0] cfg_ftw = '0;
  logic        cfg_clr = 1'b0;
  logic        rom_en;
  logic [9:0]  rom_addr;
  logic [3:0]  rom_data = '0;
  logic [3:0]  dac_a, dac_b;
  logic        sample_tick;

  int total = 0;
  int bad = 0;

  // Reference model state: phase and tuning word per channel
  int mA, mB, fA, fB;

  dual_dds_scheduler dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .run(run),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_ftw(cfg_ftw), .cfg_clr(cfg_clr),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .dac_a(dac_a), .dac_b(dac_b), .sample_tick(sample_tick)
  );

  always #5 sys_clk = ~sys_clk;

  // Waveform ROM: sample = low nibble of the address, one-cycle latency
  always @(posedge sys_clk) if (rom_en) rom_data <= rom_addr[3:0];

  // Expected sample for a phase: ROM address is phase[15:6]
  function automatic logic [3:0] smp(input int acc);
    return 4'((acc >> 6) & 15);
  endfunction

  task automatic step();
    @(negedge sys_clk);
  endtask

  // Steps until sample_tick is seen; n = cycles taken, -1 on timeout
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (sample_tick) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic cfg_send(input logic ch, input int ftw, input logic clr, output bit ok);
    ok = 0;
    cfg_valid = 1'b1; cfg_ch = ch; cfg_ftw = 16'(ftw); cfg_clr = clr;
    for (int i = 0; i < 12; i++) begin
      if (cfg_ready) begin
        step();
        ok = 1;
        break;
      end
      step();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; run = 1'b0; cfg_valid = 1'b0;
    step(); step();
    sys_rst = 1'b0;
    step();
    mA = 0; mB = 0; fA = 0; fB = 0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({dac_a, dac_b, rom_en, rom_addr, sample_tick, cfg_ready} !== 19'd0) begin
        bad++;
        $display("FAIL reset_outputs: dac_a=%h dac_b=%h rom_en=%b rom_addr=%h tick=%b ready=%b, required all 0",
                 dac_a, dac_b, rom_en, rom_addr, sample_tick, cfg_ready);
      end
    end
    sys_rst = 1'b0; run = 1'b0;
    step();
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready_after: got %b required 1", cfg_ready);
    end
  endtask

  task automatic test_basic();
    int n; bit ok;
    do_reset();
    cfg_send(1'b0, 16'h0040, 1'b0, ok); fA = 'h40;
    cfg_send(1'b1, 16'h0080, 1'b0, ok); fB = 'h80;
    total++;
    if (!ok) begin bad++; $display("FAIL basic_cfg: config not accepted, required accept"); end
    step();
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_tick(n);
      total++;
      if (n !== (k == 0 ? 4 : 3)) begin
        bad++; $display("FAIL basic_gap k=%0d: got %0d cycles required %0d", k, n, k == 0 ? 4 : 3);
      end
      total++;
      if (dac_a !== smp(mA) || dac_b !== smp(mB)) begin
        bad++; $display("FAIL basic_samples k=%0d: got (%h,%h) required (%h,%h)", k, dac_a, dac_b, smp(mA), smp(mB));
      end
      mA = (mA + fA) & 'hFFFF; mB = (mB + fB) & 'hFFFF;
    end
  endtask

  task automatic test_wrap();
    int n; bit ok;
    do_reset();
    cfg_send(1'b0, 16'hFFC0, 1'b1, ok); fA = 'hFFC0; mA = 0;
    step();
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_tick(n);
      total++;
      if (n < 0 || dac_a !== smp(mA)) begin
        bad++; $display("FAIL wrap_sample k=%0d: got %h (wait %0d) required %h", k, dac_a, n, smp(mA));
      end
      mA = (mA + fA) & 'hFFFF;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    begin bit ok; cfg_send(1'b0, 16'h0040, 1'b0, ok); cfg_send(1'b1, 16'h0080, 1'b0, ok); end
    fA = 'h40; fB = 'h80;
    step();
    run = 1'b1;
    wait_tick(n);
    total++;
    if (n !== 4 || dac_a !== 4'h0 || dac_b !== 4'h0) begin
      bad++; $display("FAIL bp_first: got (%h,%h) after %0d required (0,0) after 4", dac_a, dac_b, n);
    end
    mA = (mA + fA) & 'hFFFF; mB = (mB + fB) & 'hFFFF;
    // First config is offered while ready is high and goes in at once
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_ftw = 16'h0100; cfg_clr = 1'b0;
    total++;
    if (cfg_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1: got %b required 1", cfg_ready); end
    step();
    total++;
    if (cfg_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_drop: got %b required 0", cfg_ready); end
    cfg_ch = 1'b1; cfg_ftw = 16'h0040;
    n = 0;
    while (!cfg_ready && n < 10) begin step(); n++; end
    total++;
    if (n !== 2 || sample_tick !== 1'b1) begin
      bad++; $display("FAIL bp_second_accept: ready after %0d cycles tick=%b, required 2 cycles with tick=1", n, sample_tick);
    end
    total++;
    if (dac_a !== smp(mA) || dac_b !== smp(mB)) begin
      bad++; $display("FAIL bp_frame2: got (%h,%h) required (%h,%h)", dac_a, dac_b, smp(mA), smp(mB));
    end
    mA = (mA + fA) & 'hFFFF; mB = (mB + fB) & 'hFFFF; fA = 'h100;
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      total++;
      if (n !== (k == 0 ? 2 : 3) || dac_a !== smp(mA) || dac_b !== smp(mB)) begin
        bad++; $display("FAIL bp_frame k=%0d: got (%h,%h) after %0d required (%h,%h)", k, dac_a, dac_b, n, smp(mA), smp(mB));
      end
      if (k == 0) begin
        total++;
        if (cfg_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_return: got %b required 1", cfg_ready); end
      end
      mA = (mA + fA) & 'hFFFF; mB = (mB + fB) & 'hFFFF;
      if (k == 0) fB = 'h40;
    end
  endtask

  task automatic test_run_drop();
    int n; bit ok;
    do_reset();
    cfg_send(1'b0, 16'h0040, 1'b0, ok); cfg_send(1'b1, 16'h0080, 1'b0, ok);
    fA = 'h40; fB = 'h80;
    step();
    run = 1'b1;
    wait_tick(n); mA = (mA + fA) & 'hFFFF; mB = (mB + fB) & 'hFFFF;
    wait_tick(n); mA = (mA + fA) & 'hFFFF; mB = (mB + fB) & 'hFFFF;
    step();
    total++;
    if (rom_en !== 1'b1 || rom_addr !== 10'(mB >> 6)) begin
      bad++; $display("FAIL drop_issue_b: rom_en=%b addr=%h required 1/%h", rom_en, rom_addr, 10'(mB >> 6));
    end
    run = 1'b0;
    wait_tick(n);
    total++;
    if (n !== 2 || dac_a !== smp(mA) || dac_b !== smp(mB)) begin
      bad++; $display("FAIL drop_last_frame: got (%h,%h) after %0d required (%h,%h) after 2", dac_a, dac_b, n, smp(mA), smp(mB));
    end
    mA = (mA + fA) & 'hFFFF; mB = (mB + fB) & 'hFFFF;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (sample_tick !== 1'b0 || rom_en !== 1'b0 || rom_addr !== 10'd0 || dac_a !== 4'h2 || dac_b !== 4'h4) begin
        bad++; $display("FAIL drop_idle_hold k=%0d: tick=%b en=%b addr=%h dac=(%h,%h) required 0/0/0/(2,4)",
                        k, sample_tick, rom_en, rom_addr, dac_a, dac_b);
      end
    end
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_ftw = 16'h0080; cfg_clr = 1'b1;
    total++;
    if (cfg_ready !== 1'b1) begin bad++; $display("FAIL idle_ready_t: got %b required 1", cfg_ready); end
    step();
    cfg_valid = 1'b0; cfg_clr = 1'b0;
    total++;
    if (cfg_ready !== 1'b0) begin bad++; $display("FAIL idle_ready_t1: got %b required 0", cfg_ready); end
    step();
    total++;
    if (cfg_ready !== 1'b1) begin bad++; $display("FAIL idle_ready_t2: got %b required 1", cfg_ready); end
    mB = 0;
    run = 1'b1;
    wait_tick(n);
    total++;
    if (n !== 4 || dac_a !== smp(mA) || dac_b !== 4'h0) begin
      bad++; $display("FAIL clr_rerun: got (%h,%h) after %0d required (%h,0) after 4", dac_a, dac_b, n, smp(mA));
    end
  endtask

  task automatic test_mid_reset();
    int n; bit ok;
    do_reset();
    cfg_send(1'b0, 16'h0040, 1'b0, ok); cfg_send(1'b1, 16'h0080, 1'b0, ok);
    step();
    run = 1'b1;
    wait_tick(n);
    wait_tick(n);
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_ftw = 16'h0100; cfg_clr = 1'b0;
    step();
    cfg_valid = 1'b0;
    sys_rst = 1'b1;
    step();
    total++;
    if ({dac_a, dac_b, rom_en, rom_addr, sample_tick} !== 19'd0) begin
      bad++; $display("FAIL midrst_outputs: dac=(%h,%h) en=%b addr=%h tick=%b required all 0",
                      dac_a, dac_b, rom_en, rom_addr, sample_tick);
    end
    sys_rst = 1'b0;
    step();
    total++;
    if (rom_en !== 1'b1 || rom_addr !== 10'd0 || cfg_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_restart: en=%b addr=%h ready=%b required 1/0/1", rom_en, rom_addr, cfg_ready);
    end
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      total++;
      if (n < 0 || dac_a !== 4'h0 || dac_b !== 4'h0 || rom_addr !== 10'd0) begin
        bad++; $display("FAIL midrst_zero_ftw k=%0d: got (%h,%h) addr=%h wait=%0d required (0,0) addr 0", k, dac_a, dac_b, rom_addr, n);
      end
    end
  endtask

  task automatic test_random();
    int n, gap, newA;
    bit ok, has_new;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      fA = int'($urandom_range(0, 65535));
      fB = int'($urandom_range(0, 65535));
      cfg_send(1'b0, fA, 1'b0, ok); cfg_send(1'b1, fB, 1'b0, ok);
      step();
      run = 1'b1;
      gap = 4; has_new = 0; newA = 0;
      for (int k = 0; k < 6; k++) begin
        wait_tick(n);
        total++;
        if (n !== gap || dac_a !== smp(mA) || dac_b !== smp(mB)) begin
          bad++; $display("FAIL rand it=%0d k=%0d: got (%h,%h) after %0d required (%h,%h) after %0d",
                          it, k, dac_a, dac_b, n, smp(mA), smp(mB), gap);
        end
        mA = (mA + fA) & 'hFFFF; mB = (mB + fB) & 'hFFFF;
        if (has_new) begin fA = newA; has_new = 0; end
        total++;
        if (rom_en !== 1'b1 || rom_addr !== 10'(mA >> 6)) begin
          bad++; $display("FAIL rand_addr it=%0d k=%0d: en=%b addr=%h required 1/%h", it, k, rom_en, rom_addr, 10'(mA >> 6));
        end
        gap = 3;
        if (k == 2) begin
          newA = int'($urandom_range(0, 65535));
          cfg_send(1'b0, newA, 1'b0, ok);
          has_new = 1;
          gap = 2;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_run_drop();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
